// File: rtl/vga_text_console_pkg.sv
// Shared types and constants for the VGA text console write sequencer.
// Holds the state enum, screen geometry, ASCII codes and block-address type.
package vga_text_console_pkg;

   localparam int VGA_NORMAL_HSIZE = 800;
   localparam int VGA_NORMAL_VSIZE = 600;

   localparam int VGA_TEXT_COLS = VGA_NORMAL_HSIZE / 8;
   localparam int VGA_TEXT_ROWS = VGA_NORMAL_VSIZE / 16;

   localparam int GFX_ADDR_W = 12;

   typedef logic [GFX_ADDR_W-1:0] Graphics_block_addr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR_LINE,
      ST_CLEAR_ALL
   } Console_state_t;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_TILDE = 8'h7E;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_BS    = 8'h08;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
   endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// Character request side and block-write side of the text console.
// master: character source / observer; slave: the console itself.
interface vga_text_console_if;
   import vga_text_console_pkg::*;

   logic                 char_valid;
   logic [7:0]           char_data;
   logic                 char_ready;
   logic                 clr_req;
   logic                 write_op;
   Graphics_block_addr_t bus_addr;
   logic [7:0]           bus_data;
   logic [5:0]           cursor_row;
   logic [6:0]           cursor_col;
   logic                 busy;

   modport master (
      output char_valid, char_data, clr_req,
      input  char_ready, write_op, bus_addr, bus_data,
      input  cursor_row, cursor_col, busy
   );

   modport slave (
      input  char_valid, char_data, clr_req,
      output char_ready, write_op, bus_addr, bus_data,
      output cursor_row, cursor_col, busy
   );

endinterface

// File: rtl/vga_console_sweeper.sv
// Loadable start/length address counter used for line and screen clears.
// Ports: load/start/len arm a sweep, step advances, addr/done report progress.
module vga_console_sweeper
   import vga_text_console_pkg::*;
#(
   parameter int ADDR_W  = GFX_ADDR_W,
   parameter int RST_LEN = VGA_TEXT_COLS * VGA_TEXT_ROWS
) (
   input  logic              clk_50M,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] start,
   input  logic [ADDR_W-1:0] len,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              done
);

   localparam logic [ADDR_W-1:0] RST_REM = ADDR_W'(RST_LEN);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load) begin
         addr_d = start;
         rem_d  = len;
      end else if (step && (rem_q != '0)) begin
         addr_d = addr_q + ONE;
         rem_d  = rem_q - ONE;
      end
   end

   // Reset arms a full-screen sweep from address 0.
   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= RST_REM;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

   assign addr = addr_q;
   assign done = (rem_q == '0);

endmodule

// File: rtl/vga_text_console.sv
// Terminal-style write sequencer for the VGA text-mode controller.
// Ports: clk_50M, rst (async, active-high), bus (slave side of the console interface).
module vga_text_console
   import vga_text_console_pkg::*;
#(
   parameter int COLS   = VGA_TEXT_COLS,
   parameter int ROWS   = VGA_TEXT_ROWS,
   parameter int ADDR_W = GFX_ADDR_W
) (
   input  logic                clk_50M,
   input  logic                rst,
   vga_text_console_if.slave   bus
);

   localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] SCREEN_LEN = ADDR_W'(ROWS * COLS);
   localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
   localparam logic [5:0]        LAST_ROW   = 6'(ROWS - 1);
   localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);

   Console_state_t    state_q, state_d;
   logic              write_op_q, write_op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic [5:0]        row_q, row_d;
   logic [6:0]        col_q, col_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;

   logic              sw_load, sw_step, sw_done;
   logic [ADDR_W-1:0] sw_start, sw_len, sw_addr;

   logic [ADDR_W-1:0] cur_addr, nl_addr;
   logic [5:0]        nl_row;
   logic              accept;

   assign cur_addr = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
   assign nl_row   = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
   assign nl_addr  = ADDR_W'(nl_row) * COLS_A;
   assign accept   = bus.char_valid && ready_q;

   vga_console_sweeper #(
      .ADDR_W  (ADDR_W),
      .RST_LEN (ROWS * COLS)
   ) u_sweeper (
      .clk_50M (clk_50M),
      .rst     (rst),
      .load    (sw_load),
      .start   (sw_start),
      .len     (sw_len),
      .step    (sw_step),
      .addr    (sw_addr),
      .done    (sw_done)
   );

   always_comb begin
      state_d    = state_q;
      write_op_d = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      row_d      = row_q;
      col_d      = col_q;
      sw_load    = 1'b0;
      sw_start   = '0;
      sw_len     = '0;
      sw_step    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.clr_req) begin
               // Clear wins over a simultaneous character.
               state_d  = ST_CLEAR_ALL;
               row_d    = 6'd0;
               col_d    = 7'd0;
               sw_load  = 1'b1;
               sw_start = '0;
               sw_len   = SCREEN_LEN;
            end else if (accept) begin
               unique case (1'b1)
                  is_printable(bus.char_data): begin
                     write_op_d = 1'b1;
                     addr_d     = cur_addr;
                     data_d     = bus.char_data;
                     if (col_q == LAST_COL) begin
                        col_d    = 7'd0;
                        row_d    = nl_row;
                        state_d  = ST_CLEAR_LINE;
                        sw_load  = 1'b1;
                        sw_start = nl_addr;
                        sw_len   = COLS_A;
                     end else begin
                        col_d = col_q + 7'd1;
                     end
                  end
                  (bus.char_data == ASCII_LF): begin
                     col_d    = 7'd0;
                     row_d    = nl_row;
                     state_d  = ST_CLEAR_LINE;
                     sw_load  = 1'b1;
                     sw_start = nl_addr;
                     sw_len   = COLS_A;
                  end
                  (bus.char_data == ASCII_CR): begin
                     col_d = 7'd0;
                  end
                  (bus.char_data == ASCII_BS): begin
                     if (col_q != 7'd0) begin
                        col_d      = col_q - 7'd1;
                        write_op_d = 1'b1;
                        addr_d     = cur_addr - ONE;
                        data_d     = ASCII_SPACE;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
         ST_CLEAR_LINE, ST_CLEAR_ALL: begin
            // Done is seen one cycle after the last write, so busy
            // stays high through the final write.
            if (sw_done) begin
               state_d = ST_IDLE;
            end else begin
               write_op_d = 1'b1;
               addr_d     = sw_addr;
               data_d     = ASCII_SPACE;
               sw_step    = 1'b1;
            end
         end
         default: begin
            state_d  = ST_CLEAR_ALL;
            row_d    = 6'd0;
            col_d    = 7'd0;
            sw_load  = 1'b1;
            sw_start = '0;
            sw_len   = SCREEN_LEN;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         state_q    <= ST_CLEAR_ALL;
         write_op_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= ASCII_SPACE;
         row_q      <= 6'd0;
         col_q      <= 7'd0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         write_op_q <= write_op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         row_q      <= row_d;
         col_q      <= col_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.char_ready = ready_q;
   assign bus.write_op   = write_op_q;
   assign bus.bus_addr   = addr_q;
   assign bus.bus_data   = data_q;
   assign bus.cursor_row = row_q;
   assign bus.cursor_col = col_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Scoreboard bench for vga_text_console: expected writes are queued by the
// stimulus and popped by an independent monitor on every write strobe.
module tb_vga_text_console;

   typedef struct packed {
      logic [11:0] a;
      logic [7:0]  d;
   } exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   exp_t expq[$];

   vga_text_console_if cif();

   vga_text_console dut (
      .clk_50M (clk),
      .rst     (rst),
      .bus     (cif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && cif.write_op) begin
         if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                     cif.bus_addr, cif.bus_data);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("wr_addr", 32'(cif.bus_addr), 32'(e.a));
            chk("wr_data", 32'(cif.bus_data), 32'(e.d));
         end
      end
   end

   task automatic push_w(input int a, input logic [7:0] d);
      exp_t e;
      e.a = 12'(a);
      e.d = d;
      expq.push_back(e);
   endtask

   task automatic push_clear(input int start, input int n);
      for (int i = 0; i < n; i++) push_w(start + i, 8'h20);
   endtask

   task automatic wait_idle(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (cif.busy && cyc < budget);
      if (cif.busy) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles", cyc);
      end
   endtask

   task automatic send_char(input logic [7:0] c);
      int n;
      n = 0;
      while (!cif.char_ready && n < 10000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!cif.char_ready) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: char_ready 0 expected 1");
      end
      cif.char_valid = 1'b1;
      cif.char_data  = c;
      @(posedge clk);
      #1;
      cif.char_valid = 1'b0;
   endtask

   task automatic send_lf_and_settle();
      int cyc;
      send_char(8'h0A);
      wait_idle(500, cyc);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      int       cyc;
      int       hits;
      logic     low_ok;
      logic [7:0] c;

      tests = 0;
      fails = 0;
      rst = 1'b1;
      cif.char_valid = 1'b0;
      cif.char_data  = 8'h00;
      cif.clr_req    = 1'b0;

      drain(3);
      chk("rst_write_op", 32'(cif.write_op), 0);
      chk("rst_addr", 32'(cif.bus_addr), 0);
      chk("rst_data", 32'(cif.bus_data), 32'h20);
      chk("rst_row", 32'(cif.cursor_row), 0);
      chk("rst_col", 32'(cif.cursor_col), 0);
      chk("rst_ready", 32'(cif.char_ready), 0);
      chk("rst_busy", 32'(cif.busy), 1);

      push_clear(0, 3700);
      rst = 1'b0;
      wait_idle(5000, cyc);
      chk("init_cycles", 32'(cyc), 3701);
      chk("init_q_empty", 32'(expq.size()), 0);
      chk("init_ready", 32'(cif.char_ready), 1);
      chk("init_row", 32'(cif.cursor_row), 0);
      chk("init_col", 32'(cif.cursor_col), 0);

      push_w(0, 8'h48);
      push_w(1, 8'h69);
      send_char(8'h48);
      send_char(8'h69);
      chk("hi_col", 32'(cif.cursor_col), 2);
      chk("hi_row", 32'(cif.cursor_row), 0);
      drain(2);
      chk("hi_q_empty", 32'(expq.size()), 0);

      send_char(8'h0D);
      chk("cr0_col", 32'(cif.cursor_col), 0);
      for (int k = 1; k <= 5; k++) begin
         push_clear(k * 100, 100);
         send_lf_and_settle();
      end
      chk("row5", 32'(cif.cursor_row), 5);
      for (int i = 0; i < 99; i++) begin
         c = 8'h61 + 8'(i % 26);
         push_w(500 + i, c);
         send_char(c);
      end
      chk("col99", 32'(cif.cursor_col), 99);

      push_w(599, 8'h5A);
      push_clear(600, 100);
      send_char(8'h5A);
      low_ok = 1'b1;
      cyc = 0;
      while (cif.busy && cyc < 500) begin
         if (cif.char_ready) low_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk("wrap_ready_low", 32'(low_ok), 1);
      chk("wrap_busy_done", 32'(cif.busy), 0);
      chk("wrap_row", 32'(cif.cursor_row), 6);
      chk("wrap_col", 32'(cif.cursor_col), 0);
      chk("wrap_q_empty", 32'(expq.size()), 0);

      for (int k = 7; k <= 36; k++) begin
         push_clear(k * 100, 100);
         send_lf_and_settle();
      end
      chk("row36", 32'(cif.cursor_row), 36);
      push_clear(0, 100);
      send_lf_and_settle();
      chk("lf_wrap_row", 32'(cif.cursor_row), 0);
      chk("lf_wrap_col", 32'(cif.cursor_col), 0);
      chk("lf_wrap_q_empty", 32'(expq.size()), 0);

      push_clear(100, 100);
      send_lf_and_settle();
      push_clear(200, 100);
      send_lf_and_settle();
      send_char(8'h08);
      chk("bs0_row", 32'(cif.cursor_row), 2);
      chk("bs0_col", 32'(cif.cursor_col), 0);
      push_w(200, 8'h61);
      push_w(201, 8'h62);
      push_w(202, 8'h63);
      send_char(8'h61);
      send_char(8'h62);
      send_char(8'h63);
      chk("abc_col", 32'(cif.cursor_col), 3);
      push_w(202, 8'h20);
      send_char(8'h08);
      chk("bs_row", 32'(cif.cursor_row), 2);
      chk("bs_col", 32'(cif.cursor_col), 2);
      send_char(8'h0D);
      chk("cr_col", 32'(cif.cursor_col), 0);
      send_char(8'h07);
      chk("bel_row", 32'(cif.cursor_row), 2);
      chk("bel_col", 32'(cif.cursor_col), 0);
      drain(3);
      chk("ctl_q_empty", 32'(expq.size()), 0);

      push_clear(0, 3700);
      cif.clr_req    = 1'b1;
      cif.char_valid = 1'b1;
      cif.char_data  = 8'h58;
      @(posedge clk);
      #1;
      cif.clr_req    = 1'b0;
      cif.char_valid = 1'b0;
      chk("clr_ready", 32'(cif.char_ready), 0);
      chk("clr_busy", 32'(cif.busy), 1);
      chk("clr_row", 32'(cif.cursor_row), 0);
      chk("clr_col", 32'(cif.cursor_col), 0);

      hits = 0;
      cyc = 0;
      while (hits == 0 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (cif.write_op && cif.bus_addr == 12'd1000) hits = 1;
      end
      chk("sweep_reached_1000", 32'(hits), 1);
      #2;
      chk("mid_q_left", 32'(expq.size()), 2699);
      rst = 1'b1;
      #1;
      chk("mid_rst_write_op", 32'(cif.write_op), 0);
      chk("mid_rst_addr", 32'(cif.bus_addr), 0);
      chk("mid_rst_data", 32'(cif.bus_data), 32'h20);
      chk("mid_rst_ready", 32'(cif.char_ready), 0);
      chk("mid_rst_busy", 32'(cif.busy), 1);
      expq.delete();
      push_clear(0, 3700);
      drain(2);
      rst = 1'b0;
      wait_idle(5000, cyc);
      chk("restart_cycles", 32'(cyc), 3701);
      chk("restart_q_empty", 32'(expq.size()), 0);
      chk("restart_row", 32'(cif.cursor_row), 0);
      chk("restart_col", 32'(cif.cursor_col), 0);
      chk("restart_ready", 32'(cif.char_ready), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
